// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generates VGA-style raster timing (hsync, vsync, data enable, pixel
//   coordinates, frame-start pulse) from a fast input clock divided down to
//   the pixel rate, together with one of four built-in test patterns.
//   All outputs are registered and change together, one clock after the
//   pixel enable that selected the pixel they describe.
//
// Ports:
//   i_clk100MHz    in   1     single clock
//   i_rst_n        in   1     synchronous active-low reset
//   i_mode         in   2     pattern select, taken up only at frame wrap
//   o_hsync        out  1     horizontal sync, active level HS_POL
//   o_vsync        out  1     vertical sync, active level VS_POL
//   o_de           out  1     active-video data enable
//   o_x, o_y       out  12    current pixel coordinates
//   o_frame_start  out  1     one-clock pulse when (0,0) is presented
//   o_red/green/blue out CW   pixel colour, zero outside active video
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int   CLK_DIV = 4,
   parameter int   H_ACT   = 640,
   parameter int   H_FRONT = 16,
   parameter int   H_SYNC  = 96,
   parameter int   H_BACK  = 48,
   parameter int   V_ACT   = 480,
   parameter int   V_FRONT = 10,
   parameter int   V_SYNC  = 2,
   parameter int   V_BACK  = 33,
   parameter logic HS_POL  = 1'b0,
   parameter logic VS_POL  = 1'b0,
   parameter int   CW      = 4
) (
   input  logic          i_clk100MHz,
   input  logic          i_rst_n,
   input  logic [1:0]    i_mode,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic          o_de,
   output logic [11:0]   o_x,
   output logic [11:0]   o_y,
   output logic          o_frame_start,
   output logic [CW-1:0] o_red,
   output logic [CW-1:0] o_green,
   output logic [CW-1:0] o_blue
);

   localparam int H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;
   localparam int BAR_W   = H_ACT / 8;
   localparam int BAR_BW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [3:0]        DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [11:0]       H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0]       V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [BAR_BW-1:0] BAR_LAST = BAR_BW'(BAR_W - 1);

   // Window bounds are one bit wider than the counters so that a segment
   // ending exactly at 4096 still compares correctly.
   localparam logic [12:0] H_ACT_E  = 13'(H_ACT);
   localparam logic [12:0] H_HALF_E = 13'(H_ACT / 2);
   localparam logic [12:0] HS_BEG_E = 13'(H_ACT + H_FRONT);
   localparam logic [12:0] HS_END_E = 13'(H_ACT + H_FRONT + H_SYNC);
   localparam logic [12:0] V_ACT_E  = 13'(V_ACT);
   localparam logic [12:0] VS_BEG_E = 13'(V_ACT + V_FRONT);
   localparam logic [12:0] VS_END_E = 13'(V_ACT + V_FRONT + V_SYNC);

   logic [3:0]        div_cnt;
   logic [11:0]       h_cnt;
   logic [11:0]       v_cnt;
   logic [BAR_BW-1:0] bar_pix;   // pixel position inside the current bar
   logic [2:0]        bar_cnt;   // bar index b, valid while h_cnt < H_ACT
   logic [1:0]        mode_q;    // pattern in force for the current frame

   logic        pix_ce;
   logic        h_wrap;
   logic        v_wrap;
   logic        h_act;
   logic        v_act;
   logic        in_hs;
   logic        in_vs;
   logic        de_now;
   logic [12:0] h_ext;
   logic [12:0] v_ext;
   logic [2:0]  rgb;             // {R,G,B} on/off for the current pixel

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case/if can leave it unassigned and infer a latch.
      rgb    = 3'b000;
      h_ext  = {1'b0, h_cnt};
      v_ext  = {1'b0, v_cnt};
      pix_ce = (div_cnt == DIV_LAST);
      h_wrap = (h_cnt == H_LAST);
      v_wrap = (v_cnt == V_LAST);
      h_act  = (h_ext < H_ACT_E);
      v_act  = (v_ext < V_ACT_E);
      in_hs  = (h_ext >= HS_BEG_E) && (h_ext < HS_END_E);
      in_vs  = (v_ext >= VS_BEG_E) && (v_ext < VS_END_E);
      de_now = h_act && v_act;

      if (de_now) begin
         unique case (mode_q)
            2'd0:    rgb = (h_ext < H_HALF_E) ? 3'b100 : 3'b010;
            2'd1:    rgb = 3'b111 - bar_cnt;
            2'd2:    rgb = (h_cnt[5] ^ v_cnt[5]) ? 3'b000 : 3'b111;
            default: rgb = 3'b111;
         endcase
      end
   end

   always_ff @(posedge i_clk100MHz) begin
      if (!i_rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         div_cnt       <= 4'd0;
         h_cnt         <= 12'd0;
         v_cnt         <= 12'd0;
         bar_pix       <= '0;
         bar_cnt       <= 3'd0;
         mode_q        <= 2'd0;
         o_hsync       <= ~HS_POL;
         o_vsync       <= ~VS_POL;
         o_de          <= 1'b0;
         o_x           <= 12'd0;
         o_y           <= 12'd0;
         o_frame_start <= 1'b0;
         o_red         <= '0;
         o_green       <= '0;
         o_blue        <= '0;
      end else begin
         o_frame_start <= 1'b0;
         div_cnt       <= pix_ce ? 4'd0 : div_cnt + 4'd1;

         if (pix_ce) begin
            // Present the pixel the counters point at, then step past it.
            o_hsync       <= in_hs ? HS_POL : ~HS_POL;
            o_vsync       <= in_vs ? VS_POL : ~VS_POL;
            o_de          <= de_now;
            o_x           <= h_cnt;
            o_y           <= v_cnt;
            o_frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
            o_red         <= {CW{rgb[2]}};
            o_green       <= {CW{rgb[1]}};
            o_blue        <= {CW{rgb[0]}};

            if (h_wrap) begin
               h_cnt   <= 12'd0;
               bar_pix <= '0;
               bar_cnt <= 3'd0;
               if (v_wrap) begin
                  v_cnt  <= 12'd0;
                  // Pattern changes are only taken up as a new frame begins.
                  mode_q <= i_mode;
               end else begin
                  v_cnt <= v_cnt + 12'd1;
               end
            end else begin
               h_cnt <= h_cnt + 12'd1;
               if (h_act) begin
                  if (bar_pix == BAR_LAST) begin
                     bar_pix <= '0;
                     bar_cnt <= bar_cnt + 3'd1;
                  end else begin
                     bar_pix <= bar_pix + BAR_BW'(1);
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Purpose:
//   Self-checking bench for vga_timing_gen. Four instances share one clock:
//     a: default 640x480 timing, CLK_DIV=4, pattern 0 (line-level timing)
//     b: CLK_DIV=1, 800-pixel lines, 7-line frames, pattern 1 (colour bars)
//     c: CLK_DIV=2, 80x48 raster, pattern switch and mid-frame reset
//     d: CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, positive syncs, random i_mode and
//        reset compared every clock with an arithmetic raster model
// Ports: none.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int D_HA = 8, D_HF = 2, D_HS = 2, D_HB = 2;
   localparam int D_VA = 4, D_VF = 1, D_VS = 1, D_VB = 1;
   localparam int D_DIV   = 1;
   localparam int D_HT    = D_HA + D_HF + D_HS + D_HB;
   localparam int D_VT    = D_VA + D_VF + D_VS + D_VB;
   localparam int D_FRAME = D_HT * D_VT;

   // Packed observation: {hs, vs, de, fs, x[11:0], y[11:0], r, g, b}
   localparam logic [39:0] RST_AC = {4'b1100, 12'd0, 12'd0, 12'h000};
   localparam logic [39:0] RST_D  = 40'd0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, rst_c_n, rst_d_n;
   logic [1:0] i_mode_a, i_mode_b, i_mode_c, i_mode_d;

   logic a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;
   logic c_hs, c_vs, c_de, c_fs, d_hs, d_vs, d_de, d_fs;
   logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y;
   logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b, d_r, d_g, d_b;

   vga_timing_gen u_a (
      .i_clk100MHz(clk), .i_rst_n(rst_n), .i_mode(i_mode_a),
      .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de), .o_x(a_x), .o_y(a_y),
      .o_frame_start(a_fs), .o_red(a_r), .o_green(a_g), .o_blue(a_b));

   vga_timing_gen #(.CLK_DIV(1), .V_ACT(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_b (
      .i_clk100MHz(clk), .i_rst_n(rst_n), .i_mode(i_mode_b),
      .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_x(b_x), .o_y(b_y),
      .o_frame_start(b_fs), .o_red(b_r), .o_green(b_g), .o_blue(b_b));

   vga_timing_gen #(.CLK_DIV(2), .H_ACT(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
                    .V_ACT(40), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)) u_c (
      .i_clk100MHz(clk), .i_rst_n(rst_c_n), .i_mode(i_mode_c),
      .o_hsync(c_hs), .o_vsync(c_vs), .o_de(c_de), .o_x(c_x), .o_y(c_y),
      .o_frame_start(c_fs), .o_red(c_r), .o_green(c_g), .o_blue(c_b));

   vga_timing_gen #(.CLK_DIV(D_DIV), .H_ACT(D_HA), .H_FRONT(D_HF), .H_SYNC(D_HS),
                    .H_BACK(D_HB), .V_ACT(D_VA), .V_FRONT(D_VF), .V_SYNC(D_VS),
                    .V_BACK(D_VB), .HS_POL(1'b1), .VS_POL(1'b1)) u_d (
      .i_clk100MHz(clk), .i_rst_n(rst_d_n), .i_mode(i_mode_d),
      .o_hsync(d_hs), .o_vsync(d_vs), .o_de(d_de), .o_x(d_x), .o_y(d_y),
      .o_frame_start(d_fs), .o_red(d_r), .o_green(d_g), .o_blue(d_b));

   logic [39:0] obs_a, obs_b, obs_c, obs_d;
   assign obs_a = {a_hs, a_vs, a_de, a_fs, a_x, a_y, a_r, a_g, a_b};
   assign obs_b = {b_hs, b_vs, b_de, b_fs, b_x, b_y, b_r, b_g, b_b};
   assign obs_c = {c_hs, c_vs, c_de, c_fs, c_x, c_y, c_r, c_g, c_b};
   assign obs_d = {d_hs, d_vs, d_de, d_fs, d_x, d_y, d_r, d_g, d_b};

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected picture for instance d at raster position (x,y) in a frame
   // whose pattern is 'mode'; frame-start bit left clear.
   function automatic logic [39:0] d_pixel(input int x, input int y, input int mode);
      logic de, hs, vs;
      logic [2:0] c;
      de = (x < D_HA) && (y < D_VA);
      hs = (x >= D_HA + D_HF) && (x < D_HA + D_HF + D_HS);
      vs = (y >= D_VA + D_VF) && (y < D_VA + D_VF + D_VS);
      case (mode)
         0:       c = (x < D_HA / 2) ? 3'b100 : 3'b010;
         1:       c = 3'(7 - x / (D_HA / 8));
         2:       c = (((x / 32) + (y / 32)) % 2 == 0) ? 3'b111 : 3'b000;
         default: c = 3'b111;
      endcase
      if (!de) c = 3'b000;
      return {hs, vs, de, 1'b0, 12'(x), 12'(y), {4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
   endfunction

   // Directed-branch bookkeeping
   logic a_prev_hs = 1'b1;
   int   a_fall_t = -1, a_de_cnt = 0, a_lines = 0;
   int   b_frames = 0;
   logic [2:0] b_seen = 3'd0;
   int   c_frames = 0, c_phase = 0;
   logic c_switched = 1'b0, c_split_seen = 1'b0;
   logic [2:0] c_cb_seen = 3'd0;

   // Random-branch model state
   int   d_k = 0, d_p = 0, d_cur_mode = 0, d_next_mode = 0;
   logic [39:0] exp_d = RST_D;
   logic d_prev_hs = 1'b0;
   int   d_rise_t = -1, d_fs_t = -1;

   initial begin
      rst_n = 1'b0; rst_c_n = 1'b0; rst_d_n = 1'b0;
      i_mode_a = 2'd0; i_mode_b = 2'd1; i_mode_c = 2'd0; i_mode_d = 2'd0;
      repeat (3) @(negedge clk);
      check("a_reset", obs_a, RST_AC);
      check("b_reset", obs_b, RST_AC);
      check("c_reset", obs_c, RST_AC);
      check("d_reset", obs_d, RST_D);
      rst_n = 1'b1; rst_c_n = 1'b1; rst_d_n = 1'b1;

      fork
         begin : directed
            for (int i = 1; i <= 14500; i++) begin
               @(negedge clk);
               // ---- a: line timing and pattern-0 split ----
               if (a_prev_hs && !a_hs) begin
                  if (a_fall_t >= 0) check("a_hs_period", 40'(i - a_fall_t), 40'(3200));
                  check("a_de_per_line", 40'(a_de_cnt), 40'(2560));
                  a_de_cnt = 0;
                  a_fall_t = i;
                  a_lines++;
               end
               if (!a_prev_hs && a_hs && a_fall_t >= 0)
                  check("a_hs_low", 40'(i - a_fall_t), 40'(384));
               a_prev_hs = a_hs;
               if (a_de) a_de_cnt++;
               if (a_de && a_x == 319) check("a_x319", 40'(obs_a[11:0]), 40'(12'hF00));
               if (a_de && a_x == 320) check("a_x320", 40'(obs_a[11:0]), 40'(12'h0F0));
               if (!a_de) check("a_blank", 40'(obs_a[11:0]), 40'(12'h000));

               // ---- b: colour bars from the second frame on ----
               if (b_fs) b_frames++;
               if (b_de && b_frames == 1 && b_x == 79)
                  check("b_frame0_mode0", 40'(obs_b[11:0]), 40'(12'hF00));
               if (b_de && b_frames >= 2) begin
                  if (b_x == 79) begin
                     check("b_x79", 40'(obs_b[11:0]), 40'(12'hFFF)); b_seen[0] = 1'b1;
                  end
                  if (b_x == 80) begin
                     check("b_x80", 40'(obs_b[11:0]), 40'(12'hFF0)); b_seen[1] = 1'b1;
                  end
                  if (b_x == 639) begin
                     check("b_x639", 40'(obs_b[11:0]), 40'(12'h000)); b_seen[2] = 1'b1;
                  end
               end

               // ---- c: mid-frame mode switch, checkerboard, reset ----
               if (c_fs && c_phase == 0) c_frames++;
               if (c_frames == 1 && c_x == 0 && c_y == 20 && !c_switched) begin
                  i_mode_c = 2'd2;
                  c_switched = 1'b1;
               end
               if (c_frames == 1 && c_de && c_y > 20) begin
                  if (c_x == 31) check("c_split_x31", 40'(obs_c[11:0]), 40'(12'hF00));
                  if (c_x == 32) begin
                     check("c_split_x32", 40'(obs_c[11:0]), 40'(12'h0F0));
                     c_split_seen = 1'b1;
                  end
               end
               if (c_frames == 2 && c_phase == 0 && c_de) begin
                  if (c_x == 32 && c_y == 0) begin
                     check("c_cb_32_0", 40'(obs_c[11:0]), 40'(12'h000)); c_cb_seen[0] = 1'b1;
                  end
                  if (c_x == 32 && c_y == 32) begin
                     check("c_cb_32_32", 40'(obs_c[11:0]), 40'(12'hFFF)); c_cb_seen[1] = 1'b1;
                  end
                  if (c_x == 0 && c_y == 0) begin
                     check("c_cb_0_0", 40'(obs_c[11:0]), 40'(12'hFFF)); c_cb_seen[2] = 1'b1;
                  end
               end
               case (c_phase)
                  0: if (c_frames == 2 && c_x == 40 && c_y == 36) begin
                        rst_c_n = 1'b0; c_phase = 1;
                     end
                  1: begin check("c_rst_vals", obs_c, RST_AC); rst_c_n = 1'b1; c_phase = 2; end
                  2: begin check("c_rst_hold", obs_c, RST_AC); c_phase = 3; end
                  3: begin
                        check("c_first_px", obs_c, {4'b1111, 12'd0, 12'd0, 12'hF00});
                        c_phase = 4;
                     end
                  4: begin
                        check("c_fs_single", obs_c, {4'b1110, 12'd0, 12'd0, 12'hF00});
                        c_phase = 5;
                     end
                  5: begin
                        check("c_x1", obs_c, {4'b1110, 12'd1, 12'd0, 12'hF00});
                        c_phase = 6;
                     end
                  default: ;
               endcase
            end
         end
         begin : randomized
            for (int j = 1; j <= 3300; j++) begin
               @(negedge clk);
               // Model: the k-th released edge with k%DIV==0 presents raster
               // pixel k/DIV-1; a frame's pattern is i_mode as seen on the
               // edge that presented the previous frame's last pixel.
               if (!rst_d_n) begin
                  d_k = 0; exp_d = RST_D; d_cur_mode = 0; d_next_mode = 0;
               end else begin
                  d_k++;
                  exp_d[36] = 1'b0;
                  if (d_k % D_DIV == 0) begin
                     d_p = (d_k / D_DIV - 1) % D_FRAME;
                     if (d_p == 0) d_cur_mode = d_next_mode;
                     exp_d = d_pixel(d_p % D_HT, d_p / D_HT, d_cur_mode);
                     exp_d[36] = (d_p == 0);
                     if (d_p == D_FRAME - 1) d_next_mode = int'(i_mode_d);
                  end
               end
               check("d_model", obs_d, exp_d);

               if (j <= 300) begin
                  if (!d_prev_hs && d_hs) begin
                     if (d_rise_t >= 0) check("d_hs_period", 40'(j - d_rise_t), 40'(14));
                     d_rise_t = j;
                  end
                  if (d_prev_hs && !d_hs && d_rise_t >= 0)
                     check("d_hs_high", 40'(j - d_rise_t), 40'(2));
                  if (d_fs) begin
                     if (d_fs_t >= 0) check("d_fs_period", 40'(j - d_fs_t), 40'(98));
                     d_fs_t = j;
                  end
                  d_prev_hs = d_hs;
               end else begin
                  rst_d_n = ($urandom_range(0, 249) != 0);
               end
               if ($urandom_range(0, 15) == 0) i_mode_d = 2'($urandom_range(0, 3));
            end
         end
      join

      check("a_lines_seen", 40'(a_lines >= 3), 40'(1));
      check("b_bars_seen", 40'(b_seen), 40'(3'b111));
      check("c_split_seen", 40'(c_split_seen), 40'(1));
      check("c_cb_seen", 40'(c_cb_seen), 40'(3'b111));
      check("c_rst_seq_done", 40'(c_phase), 40'(6));
      check("d_fs_seen", 40'(d_fs_t >= 0), 40'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning input clocks per pixel (1..16).
REQ-002 SHALL have parameters H_ACT 640, H_FRONT 16, H_SYNC 96, H_BACK 48, meaning horizontal segment lengths in pixels.
REQ-003 SHALL have parameters V_ACT 480, V_FRONT 10, V_SYNC 2, V_BACK 33, meaning vertical segment lengths in lines.
REQ-004 SHALL have parameters HS_POL 0 and VS_POL 0, meaning the active sync level.
REQ-005 SHALL have parameter CW, default 4, meaning the bit width of each colour channel.
REQ-006 SHALL have port i_clk100MHz, input, 1 bit: the single clock.
REQ-007 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port i_mode, input, 2 bits: test-pattern select.
REQ-009 SHALL have ports o_hsync and o_vsync, output, 1 bit each: sync outputs.
REQ-010 SHALL have port o_de, output, 1 bit: active-video data enable.
REQ-011 SHALL have ports o_x and o_y, output, 12 bits each: current pixel coordinates.
REQ-012 SHALL have port o_frame_start, output, 1 bit: one-clock pulse at the start of each frame.
REQ-013 SHALL have ports o_red, o_green and o_blue, output, CW bits each: pixel colour.

Function
REQ-014 SHALL assert pixel enable (pix_ce) when the divider reaches CLK_DIV-1; the divider counts 0..CLK_DIV-1 and wraps; CLK_DIV=1 gives pix_ce every cycle.
REQ-015 SHALL advance h_cnt only on pix_ce: 0..H_TOTAL-1, where H_TOTAL=H_ACT+H_FRONT+H_SYNC+H_BACK; at H_TOTAL-1 it wraps to 0 and v_cnt advances.
REQ-016 SHALL wrap v_cnt from V_TOTAL-1 to 0, where V_TOTAL=V_ACT+V_FRONT+V_SYNC+V_BACK.
REQ-017 SHALL order each line as active [0,H_ACT), front porch, sync [H_ACT+H_FRONT, H_ACT+H_FRONT+H_SYNC), back porch; SHALL order each frame the same way using V parameters.
REQ-018 SHALL drive o_hsync = HS_POL while h_cnt is in the sync window, and ~HS_POL otherwise.
REQ-019 SHALL drive o_vsync = VS_POL while v_cnt is in the sync window, and ~VS_POL otherwise; o_vsync SHALL change only at h_cnt=0.
REQ-020 SHALL drive o_de=1 iff h_cnt<H_ACT and v_cnt<V_ACT.
REQ-021 SHALL drive o_x=h_cnt and o_y=v_cnt (zero-extended to 12 bits).
REQ-022 SHALL register all outputs and update them only in the clock after pix_ce; between updates they hold, except o_frame_start.
REQ-023 SHALL make all outputs mutually aligned: the same pixel in the same cycle; latency counter-to-output is 1 clock.
REQ-024 SHALL pulse o_frame_start high for exactly one i_clk100MHz cycle, the cycle in which outputs first present (0,0).
REQ-025 SHALL sample i_mode into mode_q only on the pix_ce at which counters wrap to (0,0); a mid-frame i_mode change SHALL NOT affect the current frame.
REQ-026 SHALL generate colours, when o_de=1, per mode_q:
  - 0: left half (x<H_ACT/2) red full-scale, right half green full-scale.
  - 1: 8 vertical bars of H_ACT/8 pixels each, using bar index b (0..7) from a bar counter cleared at x=0 and incremented every H_ACT/8 active pixels; {R,G,B} = 3'b111 - b, each bit replicated to CW bits.
  - 2: 32x32 checkerboard; white if x[5]^y[5]=0, black otherwise.
  - 3: solid white.
REQ-027 SHALL drive all colour outputs to 0 when o_de=0.
REQ-028 SHALL require H_TOTAL and V_TOTAL to be at most 4096, and H_ACT to be divisible by 8; out-of-range values are unsupported.

Reset
REQ-029 SHALL, on any clock edge with i_rst_n=0, clear the divider, h_cnt, v_cnt, bar counter and mode_q to 0, set o_hsync=~HS_POL and o_vsync=~VS_POL, and clear o_de, o_x, o_y, o_frame_start and all colours to 0.
REQ-030 SHALL, when reset is asserted mid-frame, take effect at the next edge; after release, the first pix_ce occurs CLK_DIV clocks later and outputs then present (0,0) with o_frame_start=1.

Verification
REQ-031 SHALL cover default parameters, mode 0: o_hsync low for 384 clocks, period 3200 clocks; o_vsync low for 6400 clocks, period 1,680,000 clocks; o_de high 2560 clocks per line.
REQ-032 SHALL cover mode 0: at x=319, RGB=(F,0,0); at x=320, RGB=(0,F,0); during blanking, RGB=(0,0,0).
REQ-033 SHALL cover mode 1 with CLK_DIV=1: the bar boundary at x=79 to 80 gives RGB F,F,F to F,F,0; x=639 gives 0,0,0.
REQ-034 SHALL cover i_mode switched 0 to 2 at y=100: the frame stays split; the next o_frame_start shows checkerboard, with (32,0) black and (32,32) white.
REQ-035 SHALL cover reset asserted at (400,200) and released: all outputs at reset values; after CLK_DIV clocks, (0,0) with a single o_frame_start pulse.
REQ-036 SHALL cover CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1: hsync high 2 clocks every 14; frame 98 clocks; o_frame_start period 98.
